mult_hilo_unit: RTL and testbench

//   Iterative shift-add multiplier for the MIPS datapath (MULT/MULTU).

---
 rtl/mult_hilo_if.sv | 29 ++
 rtl/mult_hilo_unit.sv | 102 ++++++++++
 tb/tb_mult_hilo_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mult_hilo_if.sv
// Request/result bundle between the MIPS datapath and the HI/LO multiplier.
// The master drives operands and HI/LO writes; the slave returns HI/LO and status.
interface mult_hilo_if #(
    parameter int N = 32
);
    logic         start;
    logic         is_signed;
    logic [N-1:0] operand_a;
    logic [N-1:0] operand_b;
    logic         mthi;
    logic         mtlo;
    logic [N-1:0] write_data;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         busy;
    logic         done;

    modport master (
        output start, is_signed, operand_a, operand_b,
        output mthi, mtlo, write_data,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, is_signed, operand_a, operand_b,
        input  mthi, mtlo, write_data,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mult_hilo_unit.sv
// Iterative shift-add MULT/MULTU unit with HI/LO registers.
// Sign is stripped on entry and reapplied to the 2N-bit product at the end.
module mult_hilo_unit #(
    parameter int N = 32
) (
    input  logic        clk,
    input  logic        reset,
    mult_hilo_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_mcand;
    logic [2*N:0]   r_acc;
    logic [CW-1:0]  r_cnt;
    logic           r_neg;
    logic [N-1:0]   r_hi;
    logic [N-1:0]   r_lo;
    logic           r_busy;
    logic           r_done;

    logic           w_a_neg;
    logic           w_b_neg;
    logic [N-1:0]   w_a_mag;
    logic [N-1:0]   w_b_mag;
    logic [N:0]     w_addend;
    logic [N:0]     w_sum;
    logic [2*N-1:0] w_prod;
    logic [2*N-1:0] w_res;

    assign w_a_neg  = bus.is_signed & bus.operand_a[N-1];
    assign w_b_neg  = bus.is_signed & bus.operand_b[N-1];
    // -2^(N-1) negates to itself, which is the correct unsigned magnitude
    assign w_a_mag  = w_a_neg ? (~bus.operand_a + 1'b1) : bus.operand_a;
    assign w_b_mag  = w_b_neg ? (~bus.operand_b + 1'b1) : bus.operand_b;
    assign w_addend = r_acc[0] ? {1'b0, r_mcand} : '0;
    assign w_sum    = r_acc[2*N:N] + w_addend;
    assign w_prod   = r_acc[2*N-1:0];
    assign w_res    = r_neg ? (~w_prod + 1'b1) : w_prod;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_mcand <= w_a_mag;
                        r_acc   <= {{(N+1){1'b0}}, w_b_mag};
                        r_neg   <= w_a_neg ^ w_b_neg;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        if (bus.mthi) r_hi <= bus.write_data;
                        if (bus.mtlo) r_lo <= bus.write_data;
                    end
                end
                S_RUN: begin
                    if (r_cnt == CW'(N)) begin
                        {r_hi, r_lo} <= w_res;
                        r_done       <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_acc <= {1'b0, w_sum, r_acc[N-1:1]};
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit: products, HI/LO writes, busy
// interference and mid-run reset, checked against hand-computed values.
module tb_mult_hilo_unit;
    localparam int N = 32;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_hilo_if #(.N(N)) dut_if ();

    mult_hilo_unit #(.N(N)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_mult(input string tag, input logic sgn,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp,
                            input int inj_start, input int inj_mt);
        dut_if.start      = 1'b1;
        dut_if.is_signed  = sgn;
        dut_if.operand_a  = a;
        dut_if.operand_b  = b;
        dut_if.mthi       = 1'b1;
        dut_if.write_data = 32'h0BAD0BAD;
        tick();
        dut_if.start     = 1'b0;
        dut_if.mthi      = 1'b0;
        dut_if.operand_a = ~a;
        dut_if.operand_b = b ^ 32'h5A5A5A5A;
        dut_if.is_signed = ~sgn;
        chk({tag, "_busy_start"}, 64'(dut_if.busy), 64'd1);
        chk({tag, "_start_wins"}, {dut_if.hi, dut_if.lo}, {m_hi, m_lo});
        for (int i = 1; i <= N; i++) begin
            tick();
            chk({tag, "_run_done"}, 64'(dut_if.done), 64'd0);
            chk({tag, "_run_busy"}, 64'(dut_if.busy), 64'd1);
            chk({tag, "_run_hilo"}, {dut_if.hi, dut_if.lo}, {m_hi, m_lo});
            dut_if.start      = (i == inj_start);
            dut_if.operand_a  = 32'h00000777;
            dut_if.operand_b  = 32'h00000003;
            dut_if.mtlo       = (i == inj_mt);
            dut_if.write_data = 32'hCAFEF00D;
        end
        dut_if.start = 1'b0;
        dut_if.mtlo  = 1'b0;
        tick();
        chk({tag, "_done"}, 64'(dut_if.done), 64'd1);
        chk({tag, "_busy_done"}, 64'(dut_if.busy), 64'd1);
        chk({tag, "_result"}, {dut_if.hi, dut_if.lo}, exp);
        {m_hi, m_lo} = exp;
        tick();
        chk({tag, "_done_drop"}, 64'(dut_if.done), 64'd0);
        chk({tag, "_idle"}, 64'(dut_if.busy), 64'd0);
        chk({tag, "_hold"}, {dut_if.hi, dut_if.lo}, exp);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        m_hi  = '0;
        m_lo  = '0;
        reset = 1'b0;
        dut_if.start      = 1'b0;
        dut_if.is_signed  = 1'b0;
        dut_if.operand_a  = '0;
        dut_if.operand_b  = '0;
        dut_if.mthi       = 1'b0;
        dut_if.mtlo       = 1'b0;
        dut_if.write_data = '0;

        #12;
        chk("rst_hilo", {dut_if.hi, dut_if.lo}, 64'd0);
        chk("rst_busy", 64'(dut_if.busy), 64'd0);
        chk("rst_done", 64'(dut_if.done), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("idle_busy", 64'(dut_if.busy), 64'd0);

        run_mult("multu_7x6", 1'b0, 32'd7, 32'd6,
                 64'h00000000_0000002A, 0, 0);
        run_mult("mult_m3x5", 1'b1, 32'hFFFFFFFD, 32'd5,
                 64'hFFFFFFFF_FFFFFFF1, 0, 0);
        run_mult("multu_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 64'hFFFFFFFE_00000001, 0, 0);
        run_mult("mult_min2", 1'b1, 32'h80000000, 32'h80000000,
                 64'h40000000_00000000, 0, 0);
        run_mult("mult_m1m1", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 64'h00000000_00000001, 0, 0);
        run_mult("mult_minx1", 1'b1, 32'h80000000, 32'd1,
                 64'hFFFFFFFF_80000000, 0, 0);

        dut_if.mthi       = 1'b1;
        dut_if.write_data = 32'hDEADBEEF;
        tick();
        dut_if.mthi = 1'b0;
        m_hi = 32'hDEADBEEF;
        chk("mthi", {dut_if.hi, dut_if.lo}, {m_hi, m_lo});
        dut_if.mtlo       = 1'b1;
        dut_if.write_data = 32'h12345678;
        tick();
        dut_if.mtlo = 1'b0;
        m_lo = 32'h12345678;
        chk("mtlo", {dut_if.hi, dut_if.lo}, {m_hi, m_lo});
        dut_if.mthi       = 1'b1;
        dut_if.mtlo       = 1'b1;
        dut_if.write_data = 32'h55AA55AA;
        tick();
        dut_if.mthi = 1'b0;
        dut_if.mtlo = 1'b0;
        m_hi = 32'h55AA55AA;
        m_lo = 32'h55AA55AA;
        chk("mthi_mtlo", {dut_if.hi, dut_if.lo}, {m_hi, m_lo});
        tick();
        chk("hold_idle", {dut_if.hi, dut_if.lo}, {m_hi, m_lo});

        run_mult("multu_inj", 1'b0, 32'h12345678, 32'h00000010,
                 64'h00000001_23456780, 10, 5);

        dut_if.start     = 1'b1;
        dut_if.is_signed = 1'b0;
        dut_if.operand_a = 32'd1000;
        dut_if.operand_b = 32'd1000;
        tick();
        dut_if.start = 1'b0;
        for (int i = 1; i <= 15; i++) tick();
        chk("pre_abort_busy", 64'(dut_if.busy), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_hilo", {dut_if.hi, dut_if.lo}, 64'd0);
        chk("abort_busy", 64'(dut_if.busy), 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("post_abort_done", 64'(dut_if.done), 64'd0);
        end
        chk("post_abort_hilo", {dut_if.hi, dut_if.lo}, 64'd0);

        run_mult("multu_after_rst", 1'b0, 32'd7, 32'd6,
                 64'h00000000_0000002A, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
